// File: rtl/sim_uart_agent.sv
// Bench-side UART agent: queued TX serialiser and RX deserialiser with parity/framing status.
// Runs on the system clock; one instance per UART channel.
module sim_uart_agent #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int TXQ_DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_BITS-1:0]         push_data,
  output logic [$clog2(TXQ_DEPTH):0]   txq_level,
  output logic                         txq_full,
  output logic                         tx_busy,
  output logic                         tx_overflow,
  output logic                         serial_out,
  input  logic                         serial_in,
  output logic                         rx_valid,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic                         rx_parity_err,
  output logic                         rx_frame_err,
  output logic [2:0]                   tx_state,
  output logic [2:0]                   rx_state
);

  localparam int AW        = $clog2(TXQ_DEPTH);
  localparam int CW        = AW + 1;
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(STOP_CLKS + 1);
  localparam int IW        = $clog2(DATA_BITS);

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_CLKS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [CW-1:0] DEPTH     = CW'(TXQ_DEPTH);
  localparam logic          PAR_EN    = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 1);

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_LOAD  = 3'd1;
  localparam logic [2:0] TX_START = 3'd2;
  localparam logic [2:0] TX_DATA  = 3'd3;
  localparam logic [2:0] TX_PAR   = 3'd4;
  localparam logic [2:0] TX_STOP  = 3'd5;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_PAR   = 3'd3;
  localparam logic [2:0] RX_STOP  = 3'd4;

  // Handshake: push_data is taken on any cycle push is high and the queue has room
  // (or is popped that same cycle); there is no back-pressure, a refused push only sets tx_overflow.

  // ---------------- TX queue ----------------
  logic [DATA_BITS-1:0] mem [TXQ_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 pop;
  logic                 push_ok;

  assign pop       = (tx_state == TX_IDLE) && (count != '0);
  assign push_ok   = push && ((count != DEPTH) || pop);
  assign txq_level = count;
  assign txq_full  = (count == DEPTH);
  assign tx_busy   = (tx_state != TX_IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
      if (push && !push_ok) tx_overflow <= 1'b1;
    end
  end

  // ---------------- TX serialiser ----------------
  // serial_out is updated on the same edge as the state it represents, so the line has no lag.
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic [TW-1:0]        tx_timer;
  logic [IW-1:0]        tx_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      serial_out <= 1'b1;
      tx_shreg   <= '0;
      tx_par     <= 1'b0;
      tx_timer   <= '0;
      tx_idx     <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            tx_shreg <= mem[rd_ptr];
            tx_par   <= (^mem[rd_ptr]) ^ PAR_ODD;
            tx_state <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          tx_state   <= TX_START;
          serial_out <= 1'b0;
          tx_timer   <= '0;
        end
        TX_START: begin
          if (tx_timer == BIT_LAST) begin
            tx_timer   <= '0;
            tx_idx     <= '0;
            tx_state   <= TX_DATA;
            serial_out <= tx_shreg[0];
          end else tx_timer <= tx_timer + 1'b1;
        end
        TX_DATA: begin
          if (tx_timer == BIT_LAST) begin
            tx_timer <= '0;
            if (tx_idx == IDX_LAST) begin
              tx_state   <= PAR_EN ? TX_PAR : TX_STOP;
              serial_out <= PAR_EN ? tx_par : 1'b1;
            end else begin
              tx_idx     <= tx_idx + 1'b1;
              tx_shreg   <= tx_shreg >> 1;
              serial_out <= tx_shreg[1];
            end
          end else tx_timer <= tx_timer + 1'b1;
        end
        TX_PAR: begin
          if (tx_timer == BIT_LAST) begin
            tx_timer   <= '0;
            tx_state   <= TX_STOP;
            serial_out <= 1'b1;
          end else tx_timer <= tx_timer + 1'b1;
        end
        TX_STOP: begin
          if (tx_timer == STOP_LAST) begin
            tx_timer <= '0;
            tx_state <= TX_IDLE;
          end else tx_timer <= tx_timer + 1'b1;
        end
        default: begin
          tx_state   <= TX_IDLE;
          serial_out <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- RX deserialiser ----------------
  logic                 sync1;
  logic                 sync2;
  logic                 rx_prev;
  logic                 fall;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par_bit;
  logic [TW-1:0]        rx_timer;
  logic [IW-1:0]        rx_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= serial_in;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign fall = rx_prev & ~sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state      <= RX_IDLE;
      rx_shreg      <= '0;
      rx_par_bit    <= 1'b0;
      rx_timer      <= '0;
      rx_idx        <= '0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (fall) begin
            rx_state <= RX_START;
            rx_timer <= '0;
          end
        end
        RX_START: begin
          // Half-bit sample rejects glitches shorter than the start-bit midpoint.
          if (rx_timer == HALF_LAST) begin
            rx_timer <= '0;
            rx_idx   <= '0;
            rx_state <= sync2 ? RX_IDLE : RX_DATA;
          end else rx_timer <= rx_timer + 1'b1;
        end
        RX_DATA: begin
          if (rx_timer == BIT_LAST) begin
            rx_timer <= '0;
            rx_shreg <= {sync2, rx_shreg[DATA_BITS-1:1]};
            if (rx_idx == IDX_LAST) rx_state <= PAR_EN ? RX_PAR : RX_STOP;
            else                    rx_idx   <= rx_idx + 1'b1;
          end else rx_timer <= rx_timer + 1'b1;
        end
        RX_PAR: begin
          if (rx_timer == BIT_LAST) begin
            rx_timer   <= '0;
            rx_par_bit <= sync2;
            rx_state   <= RX_STOP;
          end else rx_timer <= rx_timer + 1'b1;
        end
        RX_STOP: begin
          if (rx_timer == BIT_LAST) begin
            rx_timer      <= '0;
            rx_valid      <= 1'b1;
            rx_data       <= rx_shreg;
            rx_frame_err  <= ~sync2;
            rx_parity_err <= PAR_EN && ((^rx_shreg) ^ rx_par_bit ^ PAR_ODD);
            rx_state      <= RX_IDLE;
          end else rx_timer <= rx_timer + 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
